// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the async FIFO: credit-based reads into a 2-entry valid/ready output buffer.
// Optional delivered-word counter (word_cnt) compiled in with RD_CTRL_CNT_EN.
module fifo_rd_ctrl #(
    parameter int fw = 8
) (
    input  logic          r_clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic [fw-1:0] fifo_rdata,
    input  logic          fifo_underflow,
    output logic          fifo_rd,
    output logic [fw-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          err,
    output logic          idle
`ifdef RD_CTRL_CNT_EN
    ,
    output logic [15:0]   word_cnt
`endif
);

    logic [fw-1:0] buf_q [2];
    logic          head;
    logic          tail;
    logic          inflight;
    logic [1:0]    entries;
    logic          pop;
    logic [2:0]    credit_used;

    assign pop = m_valid && m_ready;

    // Words held plus the one in flight, after this cycle's pop frees its slot.
    assign credit_used = {1'b0, entries} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd = !rst && !fifo_empty && (credit_used < 3'd2);
    assign m_valid = (entries != 2'd0);
    assign m_data  = buf_q[head];
    assign idle    = (entries == 2'd0) && !inflight && fifo_empty;

    always_ff @(posedge r_clk) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
            inflight <= 1'b0;
            entries  <= 2'd0;
            err      <= 1'b0;
        end else begin
            inflight <= fifo_rd;
            if (inflight) begin
                buf_q[tail] <= fifo_rdata;
                tail        <= ~tail;
            end
            if (pop)
                head <= ~head;
            case ({inflight, pop})
                2'b10:   entries <= entries + 2'd1;
                2'b01:   entries <= entries - 2'd1;
                default: entries <= entries;
            endcase
            if (fifo_underflow)
                err <= 1'b1;
        end
    end

`ifdef RD_CTRL_CNT_EN
    always_ff @(posedge r_clk) begin
        if (rst)
            word_cnt <= 16'd0;
        else if (pop)
            word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized + directed bench for fifo_rd_ctrl against a queue-based model of words owed to the consumer.
module tb_fifo_rd_ctrl;
    localparam int FW = 8;

    logic          r_clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [FW-1:0] fifo_rdata = '0;
    logic          fifo_underflow = 1'b0;
    logic          fifo_rd;
    logic [FW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          err;
    logic          idle;
`ifdef RD_CTRL_CNT_EN
    logic [15:0]   word_cnt;
`endif

    fifo_rd_ctrl #(.fw(FW)) dut (
        .r_clk(r_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_underflow(fifo_underflow), .fifo_rd(fifo_rd), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .err(err), .idle(idle)
`ifdef RD_CTRL_CNT_EN
        , .word_cnt(word_cnt)
`endif
    );

    always #5 r_clk = ~r_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [FW-1:0] src[$];      // words still sitting in the FIFO
    logic [FW-1:0] pq[$];       // words read from the FIFO, not yet delivered
    int            pt[$];       // cycle from which each pq word may be presented
    logic [FW-1:0] outlog[$];   // words the DUT actually handed over
    bit            err_m = 0;
    logic [15:0]   cnt_m = 0;
    int            rd_pulses = 0;
    int            first_rd = -1;
    int            first_vld = -1;
    int            last_pop = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: inputs are already driven at posedge+1; check at mid-cycle, advance model after the edge.
    task automatic step();
        bit exp_valid, pop_e, exp_rd;
        fifo_empty = (src.size() == 0);
        #4;
        exp_valid = (pq.size() > 0) && (pt[0] <= cyc);
        pop_e     = exp_valid && m_ready;
        exp_rd    = !rst && !fifo_empty && ((pq.size() - int'(pop_e)) < 2);
        chk("fifo_rd", fifo_rd, exp_rd);
        chk("m_valid", m_valid, exp_valid);
        if (exp_valid) chk("m_data", m_data, pq[0]);
        chk("err", err, err_m);
        chk("idle", idle, (pq.size() == 0) && fifo_empty);
`ifdef RD_CTRL_CNT_EN
        chk("word_cnt", word_cnt, cnt_m);
`endif
        if (fifo_rd) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (m_valid && m_ready) begin
            outlog.push_back(m_data);
            last_pop = cyc;
        end
        @(posedge r_clk);
        #1;
        fifo_rdata = FW'($urandom);
        if (rst) begin
            pq.delete();
            pt.delete();
            err_m = 0;
            cnt_m = 0;
        end else begin
            if (pop_e) begin
                void'(pq.pop_front());
                void'(pt.pop_front());
                cnt_m++;
            end
            if (exp_rd) begin
                fifo_rdata = src.pop_front();
                pq.push_back(fifo_rdata);
                pt.push_back(cyc + 2);
            end
            if (fifo_underflow) err_m = 1;
        end
        cyc++;
        fifo_empty = (src.size() == 0);
    endtask

    task automatic clear_logs();
        outlog.delete();
        rd_pulses = 0;
        first_rd  = -1;
        first_vld = -1;
        last_pop  = -1;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && (src.size() > 0 || pq.size() > 0); i++) step();
        chk("drain_left", src.size() + pq.size(), 0);
    endtask

    task automatic load_seq(input int n);
        for (int i = 0; i < n; i++) src.push_back(FW'(i));
    endtask

    task automatic chk_seq(input string tag, input int n);
        chk({tag, "_count"}, outlog.size(), n);
        for (int i = 0; i < n && i < outlog.size(); i++) chk({tag, "_word"}, outlog[i], i);
    endtask

    initial begin
        #1;
        // Reset with data available and a ready consumer.
        load_seq(4);
        rst = 1; m_ready = 1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_m_data", m_data, 0);
        rst = 0;
        src.delete();
        fifo_empty = 1;
        step(); step();

        // Streaming: 8 words at full rate.
        clear_logs();
        load_seq(8);
        drain(40);
        chk_seq("stream", 8);
        chk("stream_latency", first_vld - first_rd, 2);
        chk("stream_back_to_back", last_pop - first_vld, 7);

        // Backpressure: only two reads while stalled, head holds word 0.
        clear_logs();
        load_seq(8);
        m_ready = 0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_rd_pulses", rd_pulses, 2);
        chk("bp_hold_data", m_data, 0);
        chk("bp_hold_valid", m_valid, 1);
        m_ready = 1;
        drain(40);
        chk_seq("bp", 8);

        // FIFO empties after three words.
        clear_logs();
        load_seq(3);
        for (int i = 0; i < 10; i++) step();
        chk_seq("empty_mid", 3);
        chk("empty_mid_valid", m_valid, 0);
        chk("empty_mid_idle", idle, 1);

        // Underflow pulse while streaming; sticky until reset.
        clear_logs();
        load_seq(6);
        step();
        fifo_underflow = 1;
        step();
        fifo_underflow = 0;
        chk("uf_err_next", err, 1);
        drain(40);
        chk_seq("uf", 6);
        chk("uf_err_sticky", err, 1);

        // Reset mid-operation discards buffered and in-flight words.
        load_seq(6);
        m_ready = 0;
        for (int i = 0; i < 3; i++) step();
        rst = 1;
        step(); step();
        rst = 0;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_err", err, 0);
        m_ready = 1;
        drain(40);

        // Random traffic with backpressure, underflow and occasional reset.
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            fifo_underflow = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 2) == 0)
                for (int k = $urandom_range(1, 4); k > 0; k--) src.push_back(FW'($urandom));
            step();
        end
        rst = 0; fifo_underflow = 0; m_ready = 1;
        drain(60);

`ifdef RD_CTRL_CNT_EN
        rst = 1; step(); rst = 0;
        chk("cnt_reset", word_cnt, 0);
        load_seq(8);
        drain(40);
        chk("cnt_8", word_cnt, 8);
        rst = 1; step(); rst = 0;
        chk("cnt_rst_mid", word_cnt, 0);
        for (int i = 0; i < 65536; i++) src.push_back(FW'(i));
        drain(65600);
        chk("cnt_wrap", word_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
